adder_iter: RTL and testbench
=============================

// Module: adder_iter
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: CHUNK bits per clock, ripple carry held in a register.
//  Valid/ready handshakes on both sides; flags carry, signed overflow and zero.
//  Used where a full-width combinational adder misses timing or area.
//  Replaces fixed 32-bit combinational adders in the iterative execute datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  CHUNK  4   bits added per cycle; WIDTH % CHUNK != 0 is an elaboration error ($error)
//  (derived) NUM_CHUNKS = WIDTH/CHUNK; IDX_W = max(1, $clog2(NUM_CHUNKS))
// PORTS
//  clk           in   1      clock, rising edge
//  reset_n       in   1      asynchronous reset, active low
//  start_valid   in   1      operands valid
//  start_ready   out  1      block can accept operands (high only in IDLE)
//  a             in   WIDTH  operand A
//  b             in   WIDTH  operand B
//  carry_in      in   1      carry in (borrow-in when subtract=1)
//  subtract      in   1      0: a+b+carry_in; 1: a-b-carry_in
//  result_valid  out  1      result outputs valid (high only in DONE)
//  result_ready  in   1      consumer accepts result
//  sum           out  WIDTH  result, modulo 2^WIDTH
//  carry_out     out  1      carry out of MSB (when subtract=1: 1 means no borrow)
//  overflow      out  1      two's-complement signed overflow
//  zero          out  1      sum == 0
// BEHAVIOUR
//  Reset (reset_n low, any state, any cycle):
//  - state=IDLE, chunk index=0, all datapath registers cleared.
//  - result_valid=0, sum=0, carry_out=0, overflow=0, zero=0.
//  - start_ready=1 (decoded from IDLE), but start_valid is ignored while reset_n is low.
//  - Reset mid-operation aborts the operation; no partial result is ever signalled.
//  FSM IDLE -> BUSY -> DONE -> IDLE. start_ready = (state==IDLE); result_valid = (state==DONE).
//  IDLE, on start_valid && start_ready:
//  - capture a, b_eff = subtract ? ~b : b, and carry = carry_in ^ subtract.
//  - clear sum; idx=0; go to BUSY.
//  BUSY, every cycle:
//  - {c, s} = a[idx*CHUNK +: CHUNK] + b_eff[same slice] + carry, with (CHUNK+1)-bit arithmetic.
//  - sum[slice] <= s; carry <= c; idx++.
//  - on the last chunk (idx == NUM_CHUNKS-1): go to DONE; idx wraps to 0.
//  DONE:
//  - sum/carry_out/overflow/zero held stable while result_valid && !result_ready.
//  - on result_ready: go to IDLE.
//  - A new operation is accepted no earlier than the cycle after the result handshake.
//  Latency: accept edge -> result_valid high exactly NUM_CHUNKS cycles later.
//  - Throughput is one result per NUM_CHUNKS+2 cycles with result_ready held high.
//  - CHUNK==WIDTH gives a latency of 1.
//  Flags:
//  - overflow = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), evaluated in DONE.
//  - carry_out = final carry register.
//  - zero = ~|sum.
//  Input handling:
//  - Inputs are sampled only on the accept edge.
//  - Changes to a/b/subtract/carry_in while BUSY/DONE have no effect.
//  - start_valid outside IDLE is ignored, not queued.
//  FORMAL: in DONE, assert {carry_out,sum} == a + b_eff + carry_eff, using captured values.
// TESTING (WIDTH=32, CHUNK=4 unless noted)
//  1. a=FFFFFFFF b=1 cin=0 sub=0 -> sum=0, carry_out=1, zero=1, overflow=0.
//     result_valid rises 8 cycles after the accept edge.
//  2. a=7FFFFFFF b=1 cin=0 sub=0 -> sum=80000000, overflow=1, carry_out=0, zero=0.
//  3. a=5 b=7 cin=0 sub=1 -> sum=FFFFFFFE, carry_out=0, overflow=0.
//     Same with cin=1 -> sum=FFFFFFFD.
//  4. Hold result_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands ->
//     outputs stable, start_ready=0, the new operands are never consumed.
//  5. Drop reset_n 3 cycles into BUSY -> result_valid=0 and start_ready=1 immediately.
//     The next op (a=1 b=2) -> sum=3.
//  6. CHUNK=32: a=80000000 b=80000000 -> 1-cycle latency, sum=0, carry_out=1, overflow=1, zero=1.

Source files
------------

// File: rtl/adder_iter_if.sv
// Operand/result bundle for the iterative adder: a start channel into the block and a result channel out of it.
// Each channel transfers on a rising clk edge where valid && ready are both high; a producer keeps valid and its payload steady until that edge.
interface adder_iter_if #(
   parameter int WIDTH = 32
) ();
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             subtract;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output start_valid, a, b, carry_in, subtract, result_ready,
      input  start_ready, result_valid, sum, carry_out, overflow, zero
   );

   modport slave (
      input  start_valid, a, b, carry_in, subtract, result_ready,
      output start_ready, result_valid, sum, carry_out, overflow, zero
   );
endinterface

// File: rtl/adder_iter.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock with the ripple carry held in a register.
// Subtraction is a + ~b + 1 with the borrow-in folded into the initial carry.
module adder_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   adder_iter_if.slave bus,
   output logic [1:0]  state
);
   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int MSB        = WIDTH - 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("adder_iter: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic             cin_r;
   logic             start_ready_r;
   logic             result_valid_r;
   logic             carry_out_r;
   logic             overflow_r;
   logic             zero_r;

   int               off;
   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] slice_mask;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH:0]   total_ref;

   // One chunk of the ripple add; sum_next is sum_r with the current slice replaced.
   always_comb begin
      off        = CHUNK * int'(idx);
      a_slice    = CHUNK'(a_r >> off);
      b_slice    = CHUNK'(b_r >> off);
      chunk_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_r};
      slice_mask = WIDTH'({CHUNK{1'b1}}) << off;
      sum_next   = (sum_r & ~slice_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << off);
      total_ref  = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         idx            <= '0;
         a_r            <= '0;
         b_r            <= '0;
         sum_r          <= '0;
         carry_r        <= 1'b0;
         cin_r          <= 1'b0;
         start_ready_r  <= 1'b1;
         result_valid_r <= 1'b0;
         carry_out_r    <= 1'b0;
         overflow_r     <= 1'b0;
         zero_r         <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start_valid) begin
                  a_r           <= bus.a;
                  b_r           <= bus.subtract ? ~bus.b : bus.b;
                  carry_r       <= bus.carry_in ^ bus.subtract;
                  cin_r         <= bus.carry_in ^ bus.subtract;
                  sum_r         <= '0;
                  idx           <= '0;
                  start_ready_r <= 1'b0;
                  state_q       <= BUSY;
               end
            end
            BUSY: begin
               sum_r   <= sum_next;
               carry_r <= chunk_sum[CHUNK];
               if (idx == IDX_W'(NUM_CHUNKS - 1)) begin
                  idx            <= '0;
                  state_q        <= DONE;
                  result_valid_r <= 1'b1;
                  carry_out_r    <= chunk_sum[CHUNK];
                  overflow_r     <= (a_r[MSB] == b_r[MSB]) && (sum_next[MSB] != a_r[MSB]);
                  zero_r         <= ~|sum_next;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.result_ready) begin
                  result_valid_r <= 1'b0;
                  start_ready_r  <= 1'b1;
                  state_q        <= IDLE;
               end
            end
            default: begin
               result_valid_r <= 1'b0;
               start_ready_r  <= 1'b1;
               state_q        <= IDLE;
            end
         endcase
      end
   end

   assign bus.start_ready  = start_ready_r;
   assign bus.result_valid = result_valid_r;
   assign bus.sum          = sum_r;
   assign bus.carry_out    = carry_out_r;
   assign bus.overflow     = overflow_r;
   assign bus.zero         = zero_r;
   assign state            = state_q;

   // The chunked result must equal the full-width sum of the captured operands.
   a_done_total: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == DONE) |-> ({carry_out_r, sum_r} == total_ref));
endmodule

// File: tb/tb_adder_iter.sv
// Bench for adder_iter: a 4-bit-chunk instance and a full-width-chunk instance, checked against
// a plain-arithmetic model of add/subtract with carry, borrow and signed overflow.
module tb_adder_iter;
   localparam int W  = 32;
   localparam int RW = W + 3;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         co;
      logic         ov;
      logic         z;
   } res_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] state_n;
   logic [1:0] state_w;
   int         n_vec = 0;
   int         n_err = 0;
   logic [RW-1:0] exp_q[$];

   always #5 clk = ~clk;

   adder_iter_if #(.WIDTH(W)) bus_n ();
   adder_iter_if #(.WIDTH(W)) bus_w ();

   adder_iter #(.WIDTH(W), .CHUNK(4)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus_n), .state(state_n)
   );
   adder_iter #(.WIDTH(W), .CHUNK(32)) dut_w (
      .clk(clk), .reset_n(reset_n), .bus(bus_w), .state(state_w)
   );

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      res_t       r;
      logic [W:0] full;
      if (!sub) begin
         full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         r.sum = full[W-1:0];
         r.co  = full[W];
         r.ov  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
      end else begin
         r.sum = a - b - {{(W-1){1'b0}}, cin};
         r.co  = ({1'b0, a} >= ({1'b0, b} + {{W{1'b0}}, cin}));
         r.ov  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
      end
      r.z = (r.sum == '0);
      return r;
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Drives one operation on the narrow instance and returns what it reports.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output res_t got, output int lat, output bit timed_out);
      int n;
      @(negedge clk);
      bus_n.a = a; bus_n.b = b; bus_n.carry_in = cin; bus_n.subtract = sub;
      bus_n.start_valid = 1'b1;
      n = 0;
      while (!bus_n.start_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 bus_n.start_valid = 1'b0;
      lat = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus_n.result_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
      got = {bus_n.sum, bus_n.carry_out, bus_n.overflow, bus_n.zero};
      bus_n.result_ready = 1'b1;
      @(posedge clk);
      #1 bus_n.result_ready = 1'b0;
   endtask

   task automatic run_op_w(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, output res_t got, output int lat, output bit timed_out);
      @(negedge clk);
      bus_w.a = a; bus_w.b = b; bus_w.carry_in = cin; bus_w.subtract = sub;
      bus_w.start_valid = 1'b1;
      @(posedge clk);
      #1 bus_w.start_valid = 1'b0;
      lat = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus_w.result_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
      got = {bus_w.sum, bus_w.carry_out, bus_w.overflow, bus_w.zero};
      bus_w.result_ready = 1'b1;
      @(posedge clk);
      #1 bus_w.result_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [RW-1:0] obs;
      bus_n.start_valid = 1'b1; bus_n.a = $urandom; bus_n.b = $urandom;
      bus_n.carry_in = 1'b0; bus_n.subtract = 1'b0; bus_n.result_ready = 1'b0;
      bus_w.start_valid = 1'b0; bus_w.a = '0; bus_w.b = '0;
      bus_w.carry_in = 1'b0; bus_w.subtract = 1'b0; bus_w.result_ready = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      obs = {bus_n.sum, bus_n.carry_out, bus_n.overflow, bus_n.zero};
      n_vec++;
      if (obs !== '0) begin
         n_err++; $display("FAIL reset_outputs got %h exp 0", obs);
      end
      n_vec++;
      if ({bus_n.start_ready, bus_n.result_valid, state_n} !== 4'b1000) begin
         n_err++; $display("FAIL reset_handshake got %b exp 1000",
                           {bus_n.start_ready, bus_n.result_valid, state_n});
      end
      bus_n.start_valid = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus_n.start_ready, state_n} !== 3'b100) begin
         n_err++; $display("FAIL reset_start_ignored got %b exp 100", {bus_n.start_ready, state_n});
      end
   endtask

   task automatic test_directed();
      logic [W-1:0]  da[4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h5};
      logic [W-1:0]  db[4] = '{32'h1, 32'h1, 32'h7, 32'h7};
      logic [1:0]    dcs[4] = '{2'b00, 2'b00, 2'b01, 2'b11};
      logic [RW-1:0] de[4] = '{{32'h0, 3'b101}, {32'h8000_0000, 3'b010},
                               {32'hFFFF_FFFE, 3'b000}, {32'hFFFF_FFFD, 3'b000}};
      res_t got; int lat; bit to;
      for (int i = 0; i < 4; i++) begin
         run_op(da[i], db[i], dcs[i][1], dcs[i][0], got, lat, to);
         n_vec++;
         if (to || lat != 8) begin
            n_err++; $display("FAIL directed_latency[%0d] got %0d timeout %0d exp 8", i, lat, to);
         end
         n_vec++;
         if (got !== de[i]) begin
            n_err++; $display("FAIL directed_result[%0d] got %h exp %h", i, got, de[i]);
         end
      end
   endtask

   task automatic test_random();
      res_t got, exp; int lat; bit to;
      logic [W-1:0] a, b; logic cin, sub;
      for (int i = 0; i < 40; i++) begin
         a = pick_operand(); b = pick_operand();
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         exp = model(a, b, cin, sub);
         run_op(a, b, cin, sub, got, lat, to);
         n_vec++;
         if (to || lat != 8 || got !== exp) begin
            n_err++; $display("FAIL random[%0d] a %h b %h cin %0d sub %0d got %h lat %0d exp %h lat 8",
                              i, a, b, cin, sub, got, lat, exp);
         end
      end
   endtask

   task automatic test_hold();
      res_t exp, obs; bit seen; bit bad_stable, bad_ready, bad_idle;
      exp = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
      @(negedge clk);
      bus_n.a = 32'h1234_5678; bus_n.b = 32'h0FED_CBA9; bus_n.carry_in = 1'b1;
      bus_n.subtract = 1'b0; bus_n.start_valid = 1'b1;
      @(posedge clk);
      #1 bus_n.start_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = bus_n.result_valid;
      end
      n_vec++;
      if (!seen) begin
         n_err++; $display("FAIL hold_wait_result got timeout exp result_valid");
      end
      bad_stable = 1'b0; bad_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         obs = {bus_n.sum, bus_n.carry_out, bus_n.overflow, bus_n.zero};
         if (obs !== exp || bus_n.result_valid !== 1'b1) bad_stable = 1'b1;
         if (bus_n.start_ready !== 1'b0) bad_ready = 1'b1;
         bus_n.start_valid = (k < 5);
         bus_n.a = $urandom; bus_n.b = $urandom; bus_n.subtract = 1'($urandom_range(0, 1));
      end
      n_vec++;
      if (bad_stable) begin
         n_err++; $display("FAIL hold_stable got %h exp %h", obs, exp);
      end
      n_vec++;
      if (bad_ready) begin
         n_err++; $display("FAIL hold_start_ready got 1 exp 0");
      end
      bus_n.result_ready = 1'b1;
      @(posedge clk);
      #1 bus_n.result_ready = 1'b0;
      bad_idle = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus_n.result_valid !== 1'b0 || bus_n.start_ready !== 1'b1) bad_idle = 1'b1;
      end
      n_vec++;
      if (bad_idle) begin
         n_err++; $display("FAIL hold_not_consumed got busy exp idle");
      end
   endtask

   task automatic test_reset_mid();
      res_t got; int lat; bit to;
      @(negedge clk);
      bus_n.a = 32'hFFFF_FFFF; bus_n.b = 32'h1; bus_n.carry_in = 1'b0; bus_n.subtract = 1'b0;
      bus_n.start_valid = 1'b1;
      @(posedge clk);
      #1 bus_n.start_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({bus_n.result_valid, bus_n.start_ready, state_n} !== 4'b0100 || bus_n.sum !== '0) begin
         n_err++; $display("FAIL reset_mid_abort got rv %0d sr %0d st %0d sum %h exp 0 1 0 0",
                           bus_n.result_valid, bus_n.start_ready, state_n, bus_n.sum);
      end
      @(negedge clk);
      bus_n.start_valid = 1'b1;
      @(negedge clk);
      bus_n.start_valid = 1'b0;
      reset_n = 1'b1;
      run_op(32'h1, 32'h2, 1'b0, 1'b0, got, lat, to);
      n_vec++;
      if (to || lat != 8 || got !== {32'h3, 3'b000}) begin
         n_err++; $display("FAIL reset_mid_next got %h lat %0d exp %h lat 8", got, lat, {32'h3, 3'b000});
      end
   endtask

   task automatic test_wide();
      res_t got, exp; int lat; bit to;
      logic [W-1:0] a, b; logic cin, sub;
      run_op_w(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, got, lat, to);
      n_vec++;
      if (to || lat != 1) begin
         n_err++; $display("FAIL wide_latency got %0d timeout %0d exp 1", lat, to);
      end
      n_vec++;
      if (got !== {32'h0, 3'b111}) begin
         n_err++; $display("FAIL wide_result got %h exp %h", got, {32'h0, 3'b111});
      end
      for (int i = 0; i < 10; i++) begin
         a = pick_operand(); b = pick_operand();
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         exp = model(a, b, cin, sub);
         run_op_w(a, b, cin, sub, got, lat, to);
         n_vec++;
         if (to || lat != 1 || got !== exp) begin
            n_err++; $display("FAIL wide_random[%0d] got %h lat %0d exp %h lat 1", i, got, lat, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] got, exp;
      int last_acc, n_acc, n_res;
      last_acc = -1; n_acc = 0; n_res = 0;
      @(negedge clk);
      bus_n.a = $urandom; bus_n.b = $urandom;
      bus_n.carry_in = 1'($urandom_range(0, 1)); bus_n.subtract = 1'($urandom_range(0, 1));
      bus_n.result_ready = 1'b1;
      bus_n.start_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i > 0) @(negedge clk);
         if (bus_n.result_valid) begin
            got = {bus_n.sum, bus_n.carry_out, bus_n.overflow, bus_n.zero};
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_res++;
            n_vec++;
            if (got !== exp) begin
               n_err++; $display("FAIL b2b_result[%0d] got %h exp %h", n_res, got, exp);
            end
         end
         if (bus_n.start_ready) begin
            exp_q.push_back(model(bus_n.a, bus_n.b, bus_n.carry_in, bus_n.subtract));
            if (last_acc >= 0) begin
               n_vec++;
               if (i - last_acc != 10) begin
                  n_err++; $display("FAIL b2b_spacing got %0d exp 10", i - last_acc);
               end
            end
            last_acc = i;
            n_acc++;
         end else begin
            bus_n.a = $urandom; bus_n.b = $urandom;
            bus_n.carry_in = 1'($urandom_range(0, 1)); bus_n.subtract = 1'($urandom_range(0, 1));
         end
      end
      @(posedge clk);
      #1 bus_n.start_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         if (bus_n.result_valid) begin
            got = {bus_n.sum, bus_n.carry_out, bus_n.overflow, bus_n.zero};
            exp = exp_q.pop_front();
            n_res++;
            n_vec++;
            if (got !== exp) begin
               n_err++; $display("FAIL b2b_drain[%0d] got %h exp %h", n_res, got, exp);
            end
         end
      end
      n_vec++;
      if (exp_q.size() != 0 || n_res != n_acc) begin
         n_err++; $display("FAIL b2b_count got %0d results exp %0d", n_res, n_acc);
      end
      bus_n.result_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_reset_mid();
      test_wide();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
